cpu_bus: RTL and testbench
==========================

# cpu_bus

Minimal 8-bit single-cycle processor that joins a 256x8 program RAM, an 8-bit program counter, six general registers, an ALU and one input and one output port on a common internal data bus. The block has two modes. In load mode an external master writes a program into RAM sequentially. In run mode the block fetches and executes one instruction per clock. It is the top-level compute block. `data_in` is its only external operand source and `data_out` is its only result port.

## Interface
- No parameters. Data width is 8 and RAM depth is 256, both fixed.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `data_in`  in  8  external input operand, read by COPY with source 110.
- `ram_we`  in  1  1 selects load mode, 0 selects run mode.
- `ram_data_in`  in  8  program byte written in load mode.
- `pc_recount`  in  1  synchronous PC clear to 0.
- `data_out`  out  8  registered output port.

## Operation
- **State:** `pc[7:0]`, registers `r0`..`r5` (8 bits each), `out_reg` (drives `data_out`), and `mem[0:255]`.
- **Reset:** while `rst`=0, `pc`, `r0`..`r5` and `data_out` are all 0, asynchronously. RAM is not reset.
- **Priority on each edge:**
  - `pc_recount`=1 sets `pc` to 0. Nothing else changes: no RAM write, no execution.
  - Otherwise `ram_we`=1 (load mode) performs `mem[pc] <= ram_data_in` and `pc <= pc+1`. Registers and `data_out` hold.
  - Otherwise `ram_we`=0 (run mode) executes `instr = mem[pc]`, read combinationally.
- **Instruction format:** `[7:6]` opcode, `[5:3]` field A, `[2:0]` field B.
- **Opcode 00, IMM:** `r0 <= {2'b00, instr[5:0]}`; `pc+1`.
- **Opcode 01, ALU:** `r3 <= r1 OP r2`; `pc+1`. OP is selected by B:
  - 000 OR, 001 NAND, 010 NOR, 011 AND
  - 100 ADD (mod 256, carry dropped), 101 SUB (r1-r2 mod 256)
  - 110 XOR, 111 XNOR
- **Opcode 10, COPY:** the source is selected by A, the destination by B; `pc+1`.
  - Source A: 000–101 select `r0`–`r5`, 110 selects `data_in`, 111 selects constant 0.
  - Destination B: 000–101 select `r0`–`r5`, 110 selects `out_reg`, 111 discards the value.
  - The source is sampled before the write, so A=B leaves the register unchanged.
- **Opcode 11, JUMP:** the condition is tested on `r3` taken as signed. If true, `pc <= r0`; otherwise `pc+1`. Condition by B:
  - 000 never, 001 =0, 010 <0, 011 <=0
  - 100 always, 101 !=0, 110 >=0, 111 >0
- **PC wrap:** increment past 255 wraps to 0 in both modes.
- **Mode switch:** leaving load mode does not rewind `pc`. The host asserts `pc_recount` for one cycle before running.

## Timing
- One instruction completes per clock, with no pipeline and no stalls.
- A register written by instruction N is visible to instruction N+1.
- `data_out` changes on the rising edge that executes COPY to 110. It holds its value otherwise and is 0 after reset.
- Load mode stores one byte per clock. `ram_data_in` must be stable around the rising edge.
- A jump target takes effect as the next fetch address.
- A `rst` assertion mid-program clears state immediately. After release, execution resumes at address 0 with the RAM contents intact.

## Test plan
- **Reset:** hold `rst`=0 with random inputs. Required: `data_out`=0 and `pc`=0. After release with `ram_we`=0 and RAM preloaded, the first instruction executed is `mem[0]`.
- **Load then run:**
  - Load this program with `ram_we`=1 (addr 0 first): 00_000_101, 10_000_001, 10_110_010, 01_000_100, 10_011_110, 00_000_000, 11_000_100.
  - Then set `ram_we`=0, pulse `pc_recount` for one cycle, and hold `data_in`=3.
  - Required: `data_out`=8 on the 5th execute edge. The pc then loops 0..6 and `data_out` stays 8.
- **ALU ops:** r1=0x0F, r2=0x3C. Required: OR→0x3F, NAND→0xF3, NOR→0xC0, AND→0x0C, ADD→0x4B, SUB→0xD3, XOR→0x33, XNOR→0xCC.
- **Conditions:** r3=0x80 (−128) and r0=0x20. Required: jump taken for B=010, 011, 100, 101. Not taken (pc+1) for 000, 001, 110, 111.
- **Wrap and recount:**
  - In load mode, 257 writes land the 257th byte at addr 0.
  - `pc_recount` asserted together with `ram_we`=1 gives `pc`=0 with no RAM write.
- **Mid-run reset:** assert `rst`=0 during the program loop. Required: `data_out` drops to 0 immediately, and execution restarts at addr 0.

Source files
------------

// File: rtl/cpu_bus.sv
// cpu_bus: minimal 8-bit single-cycle processor. A 256x8 program RAM, an
// 8-bit program counter, six general registers, an ALU and one in/out port
// share an internal data bus. In load mode a host fills RAM sequentially at
// pc. In run mode one instruction is fetched from mem[pc] and executed per clock.
module cpu_bus (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       ram_we,
    input  logic [7:0] ram_data_in,
    input  logic       pc_recount,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {
        OP_IMM  = 2'b00,
        OP_ALU  = 2'b01,
        OP_COPY = 2'b10,
        OP_JUMP = 2'b11
    } opcode_t;

    logic [7:0] mem [0:255];
    logic [7:0] pc;
    logic [7:0] regs [0:5];
    logic [7:0] out_reg;

    logic [7:0] instr;
    opcode_t    opcode;
    logic [2:0] field_a;
    logic [2:0] field_b;
    logic [7:0] alu_result;
    logic [7:0] copy_src;
    logic       jump_taken;
    logic [7:0] pc_next;
    logic       r3_zero;
    logic       r3_neg;

    // Fetch is combinational: the instruction at pc executes on this edge.
    assign instr    = mem[pc];
    assign opcode   = opcode_t'(instr[7:6]);
    assign field_a  = instr[5:3];
    assign field_b  = instr[2:0];
    assign data_out = out_reg;
    assign r3_zero  = (regs[3] == 8'h00);
    assign r3_neg   = regs[3][7];

    // ALU: r1 OP r2, operation chosen by field B; add/sub wrap modulo 256.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_result = 8'h00;
        case (field_b)
            3'd0: alu_result = regs[1] | regs[2];
            3'd1: alu_result = ~(regs[1] & regs[2]);
            3'd2: alu_result = ~(regs[1] | regs[2]);
            3'd3: alu_result = regs[1] & regs[2];
            3'd4: alu_result = regs[1] + regs[2];
            3'd5: alu_result = regs[1] - regs[2];
            3'd6: alu_result = regs[1] ^ regs[2];
            3'd7: alu_result = ~(regs[1] ^ regs[2]);
            default: alu_result = 8'h00;
        endcase
    end

    // COPY source mux: registers, external input, or constant zero.
    always_comb begin
        copy_src = 8'h00;
        case (field_a)
            3'd0: copy_src = regs[0];
            3'd1: copy_src = regs[1];
            3'd2: copy_src = regs[2];
            3'd3: copy_src = regs[3];
            3'd4: copy_src = regs[4];
            3'd5: copy_src = regs[5];
            3'd6: copy_src = data_in;
            default: copy_src = 8'h00;
        endcase
    end

    // Jump condition on r3 as a signed value, then next-pc selection.
    always_comb begin
        jump_taken = 1'b0;
        case (field_b)
            3'd0: jump_taken = 1'b0;
            3'd1: jump_taken = r3_zero;
            3'd2: jump_taken = r3_neg;
            3'd3: jump_taken = r3_neg | r3_zero;
            3'd4: jump_taken = 1'b1;
            3'd5: jump_taken = ~r3_zero;
            3'd6: jump_taken = ~r3_neg;
            3'd7: jump_taken = ~r3_neg & ~r3_zero;
            default: jump_taken = 1'b0;
        endcase
        pc_next = pc + 8'd1;
        if (opcode == OP_JUMP && jump_taken) begin
            pc_next = regs[0];
        end
    end

    // Program RAM write in load mode; recount and reset suppress the write.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset, so it maps onto plain memory and survives rst.
        if (rst && !pc_recount && ram_we) begin
            mem[pc] <= ram_data_in;
        end
    end

    // Architectural state: pc, register file and output port.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
        if (!rst) begin
            pc      <= 8'h00;
            out_reg <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (pc_recount) begin
            pc <= 8'h00;
        end else if (ram_we) begin
            pc <= pc + 8'd1;
        end else begin
            pc <= pc_next;
            case (opcode)
                OP_IMM: regs[0] <= {2'b00, instr[5:0]};
                OP_ALU: regs[3] <= alu_result;
                OP_COPY: begin
                    case (field_b)
                        3'd0: regs[0] <= copy_src;
                        3'd1: regs[1] <= copy_src;
                        3'd2: regs[2] <= copy_src;
                        3'd3: regs[3] <= copy_src;
                        3'd4: regs[4] <= copy_src;
                        3'd5: regs[5] <= copy_src;
                        3'd6: out_reg <= copy_src;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus.sv
// Testbench for cpu_bus: directed programs plus a random program, each edge
// compared with an instruction-level reference model of the processor.
module tb_cpu_bus;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       ram_we;
    logic [7:0] ram_data_in;
    logic       pc_recount;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_mem [256];
    int         m_pc;
    logic [7:0] m_r [6];
    logic [7:0] m_out;

    cpu_bus dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .ram_we     (ram_we),
        .ram_data_in(ram_data_in),
        .pc_recount (pc_recount),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input int op, input int a, input int b);
        int res;
        case (op)
            0: res = a | b;
            1: res = ~(a & b);
            2: res = ~(a | b);
            3: res = a & b;
            4: res = a + b;
            5: res = a - b;
            6: res = a ^ b;
            default: res = ~(a ^ b);
        endcase
        return 8'(res & 255);
    endfunction

    function automatic bit cond_ref(input int b, input int v);
        case (b)
            0: return 1'b0;
            1: return v == 0;
            2: return v < 0;
            3: return v <= 0;
            4: return 1'b1;
            5: return v != 0;
            6: return v >= 0;
            default: return v > 0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc  = 0;
        m_out = 8'h00;
        for (int i = 0; i < 6; i++) m_r[i] = 8'h00;
    endtask

    // One rising edge of the processor, described instruction by instruction.
    task automatic model_edge();
        logic [7:0] instr;
        logic [7:0] src;
        int op, a, b, next;
        if (!rst) begin
            model_reset();
        end else if (pc_recount) begin
            m_pc = 0;
        end else if (ram_we) begin
            m_mem[m_pc] = ram_data_in;
            m_pc = (m_pc + 1) % 256;
        end else begin
            instr = m_mem[m_pc];
            op    = int'(instr[7:6]);
            a     = int'(instr[5:3]);
            b     = int'(instr[2:0]);
            next  = (m_pc + 1) % 256;
            case (op)
                0: m_r[0] = {2'b00, instr[5:0]};
                1: m_r[3] = alu_ref(b, int'(m_r[1]), int'(m_r[2]));
                2: begin
                    if (a < 6)       src = m_r[a];
                    else if (a == 6) src = data_in;
                    else             src = 8'h00;
                    if (b < 6)       m_r[b] = src;
                    else if (b == 6) m_out = src;
                end
                default: if (cond_ref(b, int'($signed(m_r[3])))) next = int'(m_r[0]);
            endcase
            m_pc = next;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, data_out, m_out);
    endtask

    task automatic load_prog(input logic [7:0] prog [$]);
        foreach (prog[i]) begin
            ram_we      = 1'b1;
            pc_recount  = 1'b0;
            ram_data_in = prog[i];
            tick("load");
        end
        ram_we = 1'b0;
    endtask

    task automatic recount();
        ram_we     = 1'b0;
        pc_recount = 1'b1;
        tick("recount");
        pc_recount = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        ram_we     = 1'b0;
        pc_recount = 1'b0;
        repeat (n) tick(tag);
    endtask

    initial begin
        logic [7:0] prog [$];
        logic [7:0] alu_exp [8];
        bit         taken_exp [8];

        alu_exp   = '{8'h3F, 8'hF3, 8'hC0, 8'h0C, 8'h4B, 8'hD3, 8'h33, 8'hCC};
        taken_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        model_reset();

        // Reset held with random inputs: output must stay at zero.
        rst = 1'b0;
        repeat (4) begin
            data_in     = 8'($urandom);
            ram_data_in = 8'($urandom);
            ram_we      = 1'($urandom);
            pc_recount  = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset", data_out, 8'h00);
        end
        data_in = 8'h00; ram_data_in = 8'h00; ram_we = 1'b0; pc_recount = 1'b0;
        rst = 1'b1;

        // Load-then-run program: out = 5 + data_in(3) = 8 on the 5th execute edge.
        prog = '{8'h05, 8'h81, 8'hB2, 8'h44, 8'h9E, 8'h00, 8'hC4};
        load_prog(prog);
        recount();
        data_in = 8'd3;
        run(4, "prog");
        check("prog_before5", data_out, 8'h00);
        run(1, "prog");
        check("prog_edge5", data_out, 8'd8);
        run(16, "prog_loop");
        check("prog_loop_hold", data_out, 8'd8);

        // Mid-run reset: output drops immediately, execution restarts at addr 0.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_async", data_out, 8'h00);
        @(posedge clk);
        #1;
        check("midrst_held", data_out, 8'h00);
        rst = 1'b1;
        run(4, "restart");
        check("restart_before5", data_out, 8'h00);
        run(1, "restart");
        check("restart_edge5", data_out, 8'd8);

        // ALU operations with r1=0x0F, r2=0x3C; each result copied to the port.
        prog = '{8'h0F, 8'h81, 8'h3C, 8'h82};
        for (int op = 0; op < 8; op++) begin
            prog.push_back(8'(8'h40 | op));
            prog.push_back(8'h9E);
        end
        recount();
        load_prog(prog);
        recount();
        run(4, "alu_setup");
        for (int op = 0; op < 8; op++) begin
            run(2, "alu");
            check($sformatf("alu_op%0d", op), data_out, alu_exp[op]);
        end

        // Jump conditions with r3=0x80 and r0=0x20.
        for (int b = 0; b < 8; b++) begin
            prog = '{8'h3F, 8'h81, 8'h82, 8'h44, 8'h99, 8'h02, 8'h82, 8'h44,
                     8'h20, 8'(8'hC0 | b), 8'h15, 8'h86};
            while (prog.size() < 32) prog.push_back(8'hBF);
            prog.push_back(8'h2A);
            prog.push_back(8'h86);
            recount();
            load_prog(prog);
            recount();
            run(12, "cond");
            check($sformatf("cond_b%0d", b), data_out, taken_exp[b] ? 8'h2A : 8'h15);
        end

        // Wrap: the 257th loaded byte lands at addr 0; recount with ram_we writes nothing.
        prog = '{8'hBF, 8'hBF};
        for (int i = 2; i < 256; i++) prog.push_back(8'($urandom));
        prog.push_back(8'hB6);
        recount();
        load_prog(prog);
        ram_we      = 1'b1;
        pc_recount  = 1'b1;
        ram_data_in = 8'h86;
        tick("recount_we");
        pc_recount  = 1'b0;
        ram_we      = 1'b0;
        data_in     = 8'h5A;
        run(2, "wrap");
        check("wrap_addr0", data_out, 8'h5A);

        // Random program with random input operands.
        prog = {};
        for (int i = 0; i < 256; i++) prog.push_back(8'($urandom));
        recount();
        load_prog(prog);
        recount();
        repeat (400) begin
            data_in = 8'($urandom);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
